// File: rtl/ex_pipe_ctrl_if.sv
// Bundle between the execute-stage controller and the surrounding pipeline datapath.
// Latency: none; this is wiring only.
// Backpressure: mem_busy travels in here and the controller's stall/freeze strobes travel out.
interface ex_pipe_ctrl_if #(
    parameter int WORD  = 64,
    parameter int CNT_W = 16
);
    // ID-stage instruction fields and execute/memory status
    logic             id_valid;
    logic [10:0]      id_opcode;
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic [4:0]       id_rd;
    logic             ex_zero;
    logic [WORD-1:0]  ex_branch_target;
    logic             mem_busy;

    // front-end steering
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             pc_src;
    logic [WORD-1:0]  pc_target;

    // registered ID/EX control bundle
    logic             ex_valid;
    logic [10:0]      ex_opcode;
    logic [1:0]       ex_alu_op;
    logic             ex_alu_src;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_reg_write;
    logic             ex_branch;
    logic             ex_uncond;

    // status
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    // pipeline datapath side
    modport master (
        output id_valid, id_opcode, id_rn, id_rm, id_rd, ex_zero, ex_branch_target, mem_busy,
        input  pc_write, ifid_write, ifid_flush, pc_src, pc_target,
        input  ex_valid, ex_opcode, ex_alu_op, ex_alu_src, ex_rd,
        input  ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_uncond,
        input  ctrl_state, stall_count, flush_count
    );

    // controller side
    modport slave (
        input  id_valid, id_opcode, id_rn, id_rm, id_rd, ex_zero, ex_branch_target, mem_busy,
        output pc_write, ifid_write, ifid_flush, pc_src, pc_target,
        output ex_valid, ex_opcode, ex_alu_op, ex_alu_src, ex_rd,
        output ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_uncond,
        output ctrl_state, stall_count, flush_count
    );
endinterface

// File: rtl/ex_pipe_ctrl.sv
// Execute-stage controller: decodes ID into ID/EX, sequences load-use stall, branch flush, memory freeze.
// Latency: PC/IF-ID strobes combinational in the same cycle; ID/EX, ctrl_state and counters 1 cycle.
// Backpressure: mem_busy freezes PC, IF/ID and ID/EX; a load-use hazard holds PC and IF/ID for one cycle.
module ex_pipe_ctrl #(
    parameter int WORD  = 64,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_pipe_ctrl_if.slave  bus
);

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_FREEZE = 2'd3
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [10:0] opcode;
        logic [1:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        uncond;
        logic [4:0]  rd;
    } idex_t;

    state_t           state_q, state_d;
    idex_t            idex_q, dec;
    logic             rn_used, rm_used, rd_used;
    logic             taken, hazard;
    logic             pc_write_c, ifid_write_c, ifid_flush_c, pc_src_c;
    logic [WORD-1:0]  pc_target_c;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Decode the ID instruction into the control bundle and note which register fields it reads.
    // Unrecognised opcodes and empty slots become an all-zero bubble that reads nothing.
    always_comb begin
        dec     = '0;
        rn_used = 1'b0;
        rm_used = 1'b0;
        rd_used = 1'b0;
        if (bus.id_valid) begin
            casez (bus.id_opcode)
                OP_LDUR: begin
                    dec.valid     = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.mem_read  = 1'b1;
                    dec.reg_write = 1'b1;
                    rn_used       = 1'b1;
                end
                OP_STUR: begin
                    dec.valid     = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.mem_write = 1'b1;
                    rn_used       = 1'b1;
                    rd_used       = 1'b1;
                end
                OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                    dec.valid     = 1'b1;
                    dec.alu_op    = 2'b10;
                    dec.reg_write = 1'b1;
                    rn_used       = 1'b1;
                    rm_used       = 1'b1;
                end
                11'b10110100???: begin
                    dec.valid     = 1'b1;
                    dec.alu_op    = 2'b01;
                    dec.branch    = 1'b1;
                    rn_used       = 1'b1;
                    rd_used       = 1'b1;
                end
                11'b000101?????: begin
                    dec.valid     = 1'b1;
                    dec.uncond    = 1'b1;
                end
                default: ;
            endcase
            if (dec.valid) begin
                dec.opcode = bus.id_opcode;
                dec.rd     = bus.id_rd;
            end
        end
    end

    // Branch resolution and load-use detection against the instruction sitting in EX.
    // X31 is XZR, so a load into it never creates a dependency.
    always_comb begin
        taken  = idex_q.valid & (idex_q.uncond | (idex_q.branch & bus.ex_zero));
        hazard = idex_q.valid & idex_q.mem_read & (idex_q.rd != 5'd31) &
                 ((rn_used & (bus.id_rn == idex_q.rd)) |
                  (rm_used & (bus.id_rm == idex_q.rd)) |
                  (rd_used & (bus.id_rd == idex_q.rd)));
    end

    // Action register: remembers what the pipeline did on the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Choose this cycle's action: a memory hold beats a redirect, which beats a load-use bubble.
    always_comb begin
        state_d = ST_RUN;
        if (bus.mem_busy)  state_d = ST_FREEZE;
        else if (taken)    state_d = ST_FLUSH;
        else if (hazard)   state_d = ST_STALL;
    end

    // Front-end strobes for the action being taken right now.
    always_comb begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        ifid_flush_c = 1'b0;
        pc_src_c     = 1'b0;
        pc_target_c  = bus.ex_branch_target;
        case (state_d)
            ST_RUN: begin
                pc_write_c   = 1'b1;
                ifid_write_c = 1'b1;
            end
            ST_FLUSH: begin
                pc_write_c   = 1'b1;
                ifid_write_c = 1'b1;
                ifid_flush_c = 1'b1;
                pc_src_c     = 1'b1;
            end
            default: ;
        endcase
    end

    // ID/EX register: hold on freeze, bubble on flush or stall, otherwise take the decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            case (state_d)
                ST_FREEZE:          idex_q <= idex_q;
                ST_FLUSH, ST_STALL: idex_q <= '0;
                default:            idex_q <= dec;
            endcase
        end
    end

    // Saturating event counters for inserted load-use bubbles and taken redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_d == ST_STALL && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (state_d == ST_FLUSH && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_write     = pc_write_c;
    assign bus.ifid_write   = ifid_write_c;
    assign bus.ifid_flush   = ifid_flush_c;
    assign bus.pc_src       = pc_src_c;
    assign bus.pc_target    = pc_target_c;
    assign bus.ex_valid     = idex_q.valid;
    assign bus.ex_opcode    = idex_q.opcode;
    assign bus.ex_alu_op    = idex_q.alu_op;
    assign bus.ex_alu_src   = idex_q.alu_src;
    assign bus.ex_rd        = idex_q.rd;
    assign bus.ex_mem_read  = idex_q.mem_read;
    assign bus.ex_mem_write = idex_q.mem_write;
    assign bus.ex_reg_write = idex_q.reg_write;
    assign bus.ex_branch    = idex_q.branch;
    assign bus.ex_uncond    = idex_q.uncond;
    assign bus.ctrl_state   = state_q;
    assign bus.stall_count  = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Bench for ex_pipe_ctrl: directed pipeline scenarios then random traffic against an instruction-level model.
// A second instance with 2-bit counters runs in lockstep so counter saturation is reached quickly.
module tb_ex_pipe_ctrl;

    localparam int WORD = 64;
    localparam int CW   = 16;
    localparam int SW   = 2;

    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] ANDI = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] CBZ  = 11'b10110100000;
    localparam logic [10:0] BR   = 11'b00010100000;

    typedef enum int {K_NOP, K_LDUR, K_STUR, K_RTYPE, K_CBZ, K_B} kind_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_pipe_ctrl_if #(.WORD(WORD), .CNT_W(CW)) bus ();
    ex_pipe_ctrl_if #(.WORD(WORD), .CNT_W(SW)) sbus ();

    ex_pipe_ctrl #(.WORD(WORD), .CNT_W(CW)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    ex_pipe_ctrl #(.WORD(WORD), .CNT_W(SW)) dut_s (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));

    assign sbus.id_valid         = bus.id_valid;
    assign sbus.id_opcode        = bus.id_opcode;
    assign sbus.id_rn            = bus.id_rn;
    assign sbus.id_rm            = bus.id_rm;
    assign sbus.id_rd            = bus.id_rd;
    assign sbus.ex_zero          = bus.ex_zero;
    assign sbus.ex_branch_target = bus.ex_branch_target;
    assign sbus.mem_busy         = bus.mem_busy;

    int checks = 0;
    int errors = 0;

    // instruction-level model of what ID/EX holds
    bit          m_valid;
    kind_t       m_kind;
    logic [10:0] m_op;
    logic [4:0]  m_rd;
    int          m_state, m_stall, m_flush, m_stall_s, m_flush_s;

    // comb strobes observed during the most recent step
    logic        o_pc_write, o_ifid_write, o_ifid_flush, o_pc_src;
    logic [63:0] o_pc_target;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic kind_t classify(input logic [10:0] op);
        casez (op)
            11'b11111000010: return K_LDUR;
            11'b11111000000: return K_STUR;
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: return K_RTYPE;
            11'b10110100???: return K_CBZ;
            11'b000101?????: return K_B;
            default:         return K_NOP;
        endcase
    endfunction

    // {alu_op[1:0], alu_src, mem_read, mem_write, reg_write, branch, uncond}
    function automatic logic [7:0] flags_of(input kind_t k);
        case (k)
            K_LDUR:  return 8'b00_1_1_0_1_0_0;
            K_STUR:  return 8'b00_1_0_1_0_0_0;
            K_RTYPE: return 8'b10_0_0_0_1_0_0;
            K_CBZ:   return 8'b01_0_0_0_0_1_0;
            K_B:     return 8'b00_0_0_0_0_0_1;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_kind = K_NOP; m_op = '0; m_rd = '0;
        m_state = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".ex_valid"}, 64'(bus.ex_valid), 64'(m_valid));
        chk({tag, ".flags"}, 64'({bus.ex_alu_op, bus.ex_alu_src, bus.ex_mem_read, bus.ex_mem_write,
                                  bus.ex_reg_write, bus.ex_branch, bus.ex_uncond}), 64'(flags_of(m_kind)));
        if (m_valid) begin
            chk({tag, ".ex_opcode"}, 64'(bus.ex_opcode), 64'(m_op));
            chk({tag, ".ex_rd"}, 64'(bus.ex_rd), 64'(m_rd));
        end
        chk({tag, ".ctrl_state"}, 64'(bus.ctrl_state), 64'(m_state));
        chk({tag, ".stall_count"}, 64'(bus.stall_count), 64'(m_stall));
        chk({tag, ".flush_count"}, 64'(bus.flush_count), 64'(m_flush));
        chk({tag, ".stall_count_s"}, 64'(sbus.stall_count), 64'(m_stall_s));
        chk({tag, ".flush_count_s"}, 64'(sbus.flush_count), 64'(m_flush_s));
    endtask

    // One pipeline cycle; entered and left 1 time unit after a rising edge.
    task automatic step(input string tag, input logic v, input logic [10:0] op,
                        input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                        input logic z, input logic [63:0] tgt, input logic busy);
        kind_t      k;
        bit         taken, hazard;
        int         act;
        logic [4:0] srcs[$];
        bus.id_valid = v; bus.id_opcode = op; bus.id_rn = rn; bus.id_rm = rm; bus.id_rd = rd;
        bus.ex_zero = z; bus.ex_branch_target = tgt; bus.mem_busy = busy;
        k = v ? classify(op) : K_NOP;
        if (k != K_NOP && k != K_B)     srcs.push_back(rn);
        if (k == K_RTYPE)               srcs.push_back(rm);
        if (k == K_STUR || k == K_CBZ)  srcs.push_back(rd);
        taken  = m_valid && (m_kind == K_B || (m_kind == K_CBZ && z));
        hazard = 0;
        if (m_valid && m_kind == K_LDUR && m_rd != 5'd31)
            foreach (srcs[i]) if (srcs[i] == m_rd) hazard = 1;
        act = busy ? 3 : taken ? 2 : hazard ? 1 : 0;
        #2;
        o_pc_write = bus.pc_write; o_ifid_write = bus.ifid_write; o_ifid_flush = bus.ifid_flush;
        o_pc_src = bus.pc_src; o_pc_target = bus.pc_target;
        chk({tag, ".pc_write"}, 64'(o_pc_write), 64'(act == 0 || act == 2));
        chk({tag, ".ifid_write"}, 64'(o_ifid_write), 64'(act == 0 || act == 2));
        chk({tag, ".ifid_flush"}, 64'(o_ifid_flush), 64'(act == 2));
        chk({tag, ".pc_src"}, 64'(o_pc_src), 64'(act == 2));
        chk({tag, ".pc_target"}, o_pc_target, tgt);
        @(posedge clk);
        #1;
        if (act == 1 || act == 2) begin
            m_valid = 0; m_kind = K_NOP;
        end else if (act == 0) begin
            m_valid = (k != K_NOP); m_kind = k; m_op = op; m_rd = rd;
        end
        if (act == 1) begin m_stall = sat(m_stall, 65535); m_stall_s = sat(m_stall_s, 3); end
        if (act == 2) begin m_flush = sat(m_flush, 65535); m_flush_s = sat(m_flush_s, 3); end
        m_state = act;
        chk_regs(tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".ex_valid"}, 64'(bus.ex_valid), 64'd0);
        chk({tag, ".ctrl_state"}, 64'(bus.ctrl_state), 64'd0);
        chk({tag, ".stall_count"}, 64'(bus.stall_count), 64'd0);
        chk({tag, ".flush_count"}, 64'(bus.flush_count), 64'd0);
        chk({tag, ".stall_count_s"}, 64'(sbus.stall_count), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [10:0] rop;
    logic [4:0]  regs[4] = '{5'd1, 5'd2, 5'd3, 5'd31};
    int          base_stall;

    initial begin
        bus.id_valid = 0; bus.id_opcode = '0; bus.id_rn = '0; bus.id_rm = '0; bus.id_rd = '0;
        bus.ex_zero = 0; bus.ex_branch_target = '0; bus.mem_busy = 0;
        model_reset();
        @(posedge clk);
        #1;
        async_reset("rst0");

        // empty pipe after reset runs freely
        step("idle", 0, '0, 0, 0, 0, 0, 64'h0, 0);
        chk("idle.pc_write_is_1", 64'(o_pc_write), 64'd1);

        // ADD X3,X1,X2
        step("add", 1, ADD, 5'd1, 5'd2, 5'd3, 0, 64'h0, 0);
        chk("add.alu_op", 64'(bus.ex_alu_op), 64'd2);
        chk("add.alu_src", 64'(bus.ex_alu_src), 64'd0);
        chk("add.reg_write", 64'(bus.ex_reg_write), 64'd1);
        chk("add.rd", 64'(bus.ex_rd), 64'd3);

        // LDUR X5 then ADD reading X5 through Rm: one bubble, then ADD issues
        step("ldur5", 1, LDUR, 5'd1, 5'd0, 5'd5, 0, 64'h0, 0);
        step("lu_stall", 1, ADD, 5'd2, 5'd5, 5'd6, 0, 64'h0, 0);
        chk("lu_stall.pc_write", 64'(o_pc_write), 64'd0);
        chk("lu_stall.ctrl_state", 64'(bus.ctrl_state), 64'd1);
        chk("lu_stall.stall_count", 64'(bus.stall_count), 64'd1);
        step("lu_issue", 1, ADD, 5'd2, 5'd5, 5'd6, 0, 64'h0, 0);
        chk("lu_issue.ex_valid", 64'(bus.ex_valid), 64'd1);
        chk("lu_issue.ctrl_state", 64'(bus.ctrl_state), 64'd0);

        // load into XZR never stalls
        step("ldur31", 1, LDUR, 5'd1, 5'd0, 5'd31, 0, 64'h0, 0);
        step("xzr_use", 1, ADD, 5'd31, 5'd31, 5'd7, 0, 64'h0, 0);
        chk("xzr_use.stall_count", 64'(bus.stall_count), 64'd1);

        // CBZ taken and not taken
        step("cbz_t_ld", 1, CBZ, 5'd0, 5'd0, 5'd7, 0, 64'h0, 0);
        step("cbz_t", 1, ADD, 5'd1, 5'd2, 5'd3, 1, 64'h100, 0);
        chk("cbz_t.pc_src", 64'(o_pc_src), 64'd1);
        chk("cbz_t.pc_target", o_pc_target, 64'h100);
        chk("cbz_t.ifid_flush", 64'(o_ifid_flush), 64'd1);
        chk("cbz_t.flush_count", 64'(bus.flush_count), 64'd1);
        step("cbz_n_ld", 1, CBZ, 5'd0, 5'd0, 5'd7, 0, 64'h0, 0);
        step("cbz_n", 1, ADD, 5'd1, 5'd2, 5'd3, 0, 64'h100, 0);
        chk("cbz_n.pc_src", 64'(o_pc_src), 64'd0);
        chk("cbz_n.flush_count", 64'(bus.flush_count), 64'd1);

        // B in EX held by mem_busy for three cycles, then redirects
        base_stall = m_stall;
        step("b_ld", 1, BR, 5'd0, 5'd0, 5'd0, 0, 64'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step("frz", 1, ADD, 5'd1, 5'd2, 5'd3, 0, 64'h240, 1);
            chk("frz.pc_write", 64'(o_pc_write), 64'd0);
            chk("frz.ctrl_state", 64'(bus.ctrl_state), 64'd3);
            chk("frz.b_held", 64'(bus.ex_uncond), 64'd1);
        end
        step("b_go", 1, ADD, 5'd1, 5'd2, 5'd3, 0, 64'h240, 0);
        chk("b_go.pc_src", 64'(o_pc_src), 64'd1);
        chk("b_go.flush_count", 64'(bus.flush_count), 64'd2);
        chk("b_go.stall_count", 64'(bus.stall_count), 64'(base_stall));

        // four load-use bubbles: narrow counters pin at all-ones
        for (int i = 0; i < 4; i++) begin
            step("sat_ld", 1, LDUR, 5'd2, 5'd0, 5'd4, 0, 64'h0, 0);
            step("sat_use", 1, STUR, 5'd1, 5'd0, 5'd4, 0, 64'h0, 0);
        end
        chk("sat.stall_count_s", 64'(sbus.stall_count), 64'd3);
        chk("sat.stall_count", 64'(bus.stall_count), 64'(base_stall + 4));

        // random traffic with one asynchronous reset in the middle
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 8))
                0: rop = LDUR;
                1: rop = STUR;
                2: rop = ADD;
                3: rop = SUB;
                4: rop = ANDI;
                5: rop = ORR;
                6: rop = CBZ | 11'($urandom_range(0, 7));
                7: rop = BR | 11'($urandom_range(0, 31));
                default: rop = 11'($urandom);
            endcase
            if (n == 300) async_reset("rst_mid");
            step("rnd", ($urandom_range(0, 9) != 0), rop,
                 regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
                 1'($urandom), {$urandom, $urandom}, ($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_pipe_ctrl.md
Name: ex_pipe_ctrl

Overview:
- Pipeline controller for the execute stage of the 5-stage ARMv8 (LEGv8 subset) core.
- Decodes the ID-stage opcode into the execute control bundle (alu_op, alu_src, branch/memory/writeback flags) and registers it into ID/EX.
- Detects load-use hazards, resolves taken branches from execute-stage results, and sequences stall, flush and freeze of PC, IF/ID and ID/EX.
- Keeps saturating stall and flush event counters.

Parameters:
- WORD, 64, datapath width for pc_target and ex_branch_target.
- CNT_W, 16, width of the stall/flush event counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  11  instruction[31:21] in ID.
- id_rn  in  5  source register Rn.
- id_rm  in  5  source register Rm.
- id_rd  in  5  Rd/Rt field.
- ex_zero  in  1  ALU zero flag of the instruction currently in EX.
- ex_branch_target  in  WORD  branch adder output of EX.
- mem_busy  in  1  MEM stage not ready; whole front end must hold.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP (valid=0).
- pc_src  out  1  1 = PC loads pc_target.
- pc_target  out  WORD  redirect address; equals ex_branch_target.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_opcode  out  11  registered opcode to ALU control.
- ex_alu_op  out  2  00 mem, 01 CBZ, 10 R-type.
- ex_alu_src  out  1  1 = immediate operand.
- ex_rd  out  5  registered Rd/Rt.
- ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_uncond  out  1 each  registered control flags.
- ctrl_state  out  2  action taken last cycle: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE.
- stall_count  out  CNT_W  load-use bubbles inserted, saturating.
- flush_count  out  CNT_W  taken branches, saturating.

Behaviour:
- Reset: all ID/EX outputs 0 (ex_valid=0), ctrl_state=RUN, both counters 0. Reset is effective immediately, including mid-stall or mid-flush.
- Decode:
  - LDUR 11111000010: alu_op 00, alu_src 1, mem_read 1, reg_write 1.
  - STUR 11111000000: alu_op 00, alu_src 1, mem_write 1.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: alu_op 10, alu_src 0, reg_write 1.
  - CBZ 10110100xxx: alu_op 01, branch 1.
  - B 000101xxxxx: uncond 1.
  - Any other opcode: decoded as NOP; all flags 0, valid 0.
- Source use:
  - Rn: all non-B instructions.
  - Rm: R-type only.
  - Rd/Rt: STUR and CBZ only.
- taken = ex_valid & (ex_uncond | (ex_branch & ex_zero)).
- hazard = ex_valid & ex_mem_read & ex_rd!=31 & id_valid & ex_rd matches any used source.
- Per-cycle priority:
  1. FREEZE (mem_busy=1): pc_write=0, ifid_write=0, ID/EX holds, no flush.
  2. FLUSH (taken): pc_write=1, pc_src=1, ifid_flush=1, ID/EX loads bubble, flush_count+1.
  3. STALL (hazard): pc_write=0, ifid_write=0, ID/EX loads bubble, stall_count+1.
  4. RUN: pc_write=1, ifid_write=1, pc_src=0, ID/EX loads the decoded ID instruction.
- pc_src, pc_write, ifid_write, ifid_flush and pc_target are combinational from registered ID/EX state and current inputs. ID/EX, ctrl_state and counters update on the clock edge.
- Taken branch together with hazard: FLUSH wins; the hazard instruction is squashed and stall_count does not increment.
- mem_busy together with taken: FREEZE wins; the branch stays in EX and flushes on the first cycle mem_busy=0.
- A load-use stall lasts exactly 1 cycle, because the bubble clears ex_mem_read.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Reset: rst_n=0 mid-run → ex_valid=0, ctrl_state=0, counters 0 without waiting for a clock edge; pc_write=1 after release with id_valid=0.
- ADD X3,X1,X2 (opcode 10001011000) → next cycle ex_alu_op=10, ex_alu_src=0, ex_reg_write=1, ex_rd=3, ex_valid=1.
- LDUR X5 then ADD with Rm=5 → one cycle pc_write=0, ifid_write=0, ex_valid=0, ctrl_state=1, stall_count=1; ADD issues next cycle. Repeat with ex_rd=31 → no stall.
- CBZ in EX with ex_zero=1, ex_branch_target=0x100 → pc_src=1, pc_target=0x100, ifid_flush=1, next ex_valid=0, flush_count=1. Same with ex_zero=0 → no flush.
- B in EX while mem_busy=1 for 3 cycles → pc_write=0 and ID/EX held for 3 cycles, ctrl_state=3; flush fires on cycle 4; simultaneous hazard is dropped and stall_count stays unchanged.
- Force stall_count to 0xFFFE, apply 3 more hazards → count holds at 0xFFFF.
